key_event_queue: RTL and testbench
==================================

# key_event_queue

Debounces the per-key `key_down` bitmap from the capture recognizer and turns each accepted state change into a note-on or note-off event. Events are serialized through a small FIFO toward the sound/synth stage. The block sits directly downstream of the recognizer, in the `clk` domain. It guarantees that every debounced transition is delivered, with backpressure and no loss.

## Interface
- `NUM_KEYS`, default 39: highest key index; the bitmap is `NUM_KEYS+1` bits wide; legal range 1..63.
- `STABLE_CYCLES`, default 1024: cycles a raw level must persist before it is accepted; legal range 1..65535.
- `FIFO_DEPTH`, default 8: event FIFO entries; must be a power of two, at least 2.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `key_down`  in  NUM_KEYS+1  raw per-key pressed bitmap from the recognizer.
- `key_state`  out  NUM_KEYS+1  debounced, accepted key levels.
- `ev_valid`  out  1  event available at FIFO head.
- `ev_ready`  in  1  consumer accepts the head event.
- `ev_key`  out  6  key index of the head event.
- `ev_on`  out  1  1 = note-on, 0 = note-off.
- `pending_any`  out  1  OR of all per-key pending flags.

## Operation
- **Input register.** `raw <= key_down` every cycle. Nothing else reads `key_down` directly.
- **Per-key debounce.** Each key `i` has a 16-bit counter `cnt[i]`, and holds `key_state[i]` and `pending[i]`.
  - If `raw[i] == key_state[i]`: `cnt[i] <= 0`.
  - Otherwise, if `cnt[i] == STABLE_CYCLES-1`: `key_state[i] <= raw[i]`, `cnt[i] <= 0`, `pending[i] <= 1`.
  - Otherwise: `cnt[i] <= cnt[i] + 1`.
  - A glitch shorter than `STABLE_CYCLES` cycles resets the counter and produces no event.
- **Scanner.** `ptr` visits keys 0..NUM_KEYS, one key per cycle, and wraps from NUM_KEYS to 0.
  - `pending[ptr] == 0`: `ptr` advances.
  - `pending[ptr] == 1` and FIFO not full: push `{ptr, key_state[ptr]}`, clear `pending[ptr]`, advance `ptr`.
  - `pending[ptr] == 1` and FIFO full: `ptr` holds and nothing is dropped.
- **Pending conflicts.**
  - A debounce toggle and a scanner clear of the same `pending[i]` in one cycle: the toggle wins and `pending[i]` stays 1.
  - Two toggles before the key is scanned coalesce into one event carrying the `key_state` at scan time.
- **FIFO.** First-word fall-through, `FIFO_DEPTH` entries of 7 bits.
  - `ev_valid = (count != 0)`. A pop occurs when `ev_valid && ev_ready`.
  - Full is evaluated on the registered count. A pop in the same cycle does not let a push into a full FIFO; the push proceeds the next cycle.
  - Simultaneous push and pop when the FIFO is neither empty nor full: count is unchanged and pointers wrap modulo `FIFO_DEPTH`.
  - `ev_key` and `ev_on` are forced to 0 while `ev_valid == 0`.
- **Reset.** Asynchronous assertion sets all of the following, regardless of any operation in progress:
  - `raw`, `cnt`, `key_state`, `pending` cleared to 0;
  - `ptr` = 0;
  - FIFO pointers and count = 0;
  - `ev_valid`, `ev_key`, `ev_on`, `pending_any` = 0.
  - Queued events are discarded. Keys still held after release of reset produce fresh note-on events after debounce.

## Timing
- Let edge E be the first edge at which `key_down[i]` is sampled at a new level, with the level held thereafter.
  - `key_state[i]` changes at edge E+STABLE_CYCLES.
  - `pending[i]` and `pending_any` rise at the same edge.
- Scan latency: the event is pushed 0..NUM_KEYS cycles after `pending[i]` sets, with an empty FIFO and no other pending keys.
- `ev_valid` rises on the edge after the push.
- Throughput: at most one push and one pop per cycle.
- A sustained `ev_ready == 0` stalls the scanner once the FIFO is full. Debounce counters keep running during the stall.
- `pending_any` is registered: it reflects `pending` after each edge.

## Test plan
- **Clean press and release.** `STABLE_CYCLES=4`; set `key_down[5]=1` for 20 cycles, then 0, with `ev_ready=1`.
  - `key_state[5]` rises 4 edges after sampling.
  - Events observed: (5, on=1), then (5, on=0).
  - No other events.
- **Glitch rejection.** Pulse `key_down[7]` high for 3 cycles with `STABLE_CYCLES=4`.
  - `key_state` stays 0 and `ev_valid` never asserts.
- **Simultaneous keys.** Raise keys 0, 12 and 39 in the same cycle.
  - Exactly three note-on events, in scan order starting from the current `ptr`.
  - Each event has `ev_on=1` and the correct `ev_key`.
- **Backpressure.** Hold `ev_ready=0`; press 10 keys with `FIFO_DEPTH=8`.
  - `ev_valid` stays 1 and the FIFO holds 8 events.
  - `pending_any` stays 1.
  - After `ev_ready=1`: all 10 events are delivered, none lost or duplicated.
- **Coalescing.** With `ev_ready=0` and the FIFO full, press then release key 3, each level held for `STABLE_CYCLES`.
  - After draining: exactly one event for key 3, with `ev_on=0`.
- **Reset mid-operation.** Assert `rst` with 5 events queued and key 2 held.
  - All outputs read 0 immediately.
  - After release: a single (2, on=1) event appears after `STABLE_CYCLES+1..NUM_KEYS+STABLE_CYCLES+2` cycles.

Source files
------------

// File: rtl/key_event_queue.sv
// key_event_queue
//   Debounces the raw per-key pressed bitmap coming from the capture
//   recognizer. Each accepted level change of a key raises a per-key pending
//   flag. A round-robin scanner turns pending flags into note-on/note-off
//   events. Events pass through a small first-word-fall-through FIFO toward
//   the synth stage. Backpressure never drops an event. If a key toggles
//   twice before it is scanned, the two changes merge into one event that
//   carries the level at scan time.
//
// Parameters
//   NUM_KEYS       highest key index (bitmap is NUM_KEYS+1 wide), 1..63
//   STABLE_CYCLES  cycles a raw level must persist before acceptance, 1..65535
//   FIFO_DEPTH     event FIFO entries, power of two, >= 2
//
// Ports
//   clk          clock
//   rst          asynchronous, active-low reset
//   key_down     raw per-key pressed bitmap
//   key_state    debounced, accepted key levels
//   ev_valid     event available at FIFO head
//   ev_ready     consumer accepts the head event
//   ev_key       key index of the head event (0 while ev_valid is low)
//   ev_on        1 = note-on, 0 = note-off (0 while ev_valid is low)
//   pending_any  OR of all per-key pending flags, registered

module key_event_queue #(
  parameter int unsigned NUM_KEYS      = 39,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_KEYS:0] key_down,
  output logic [NUM_KEYS:0] key_state,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [5:0]        ev_key,
  output logic              ev_on,
  output logic              pending_any
);

  localparam int unsigned AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [15:0]   CNT_LAST = 16'(STABLE_CYCLES - 1);
  localparam logic [5:0]    PTR_LAST = 6'(NUM_KEYS);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Input register: the only consumer of key_down.
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS:0] raw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) raw <= '0;
    else      raw <= key_down;
  end

  // ---------------------------------------------------------------------------
  // Per-key debounce.
  // A key's counter runs only while raw disagrees with the accepted level.
  // Any agreement clears the counter, so a glitch shorter than STABLE_CYCLES
  // leaves no trace.
  // ---------------------------------------------------------------------------
  logic [15:0]       cnt [NUM_KEYS+1];
  logic [NUM_KEYS:0] accept;

  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i <= NUM_KEYS; i++) begin
      accept[i] = (raw[i] != key_state[i]) && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_state <= '0;
      for (int unsigned i = 0; i <= NUM_KEYS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i <= NUM_KEYS; i++) begin
        if (raw[i] == key_state[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          key_state[i] <= raw[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scanner.
  // ptr visits one key per cycle. It stalls on a pending key only while the
  // FIFO is full.
  // ---------------------------------------------------------------------------
  logic [5:0]        ptr;
  logic [NUM_KEYS:0] pending;
  logic [NUM_KEYS:0] pending_nxt;
  logic              cur_pending;
  logic              cur_state;
  logic              full;
  logic              push;
  logic              pop;
  logic              stall;
  logic [CW-1:0]     count;

  // Explicit compare-select rather than a variable bit-select. This keeps the
  // index width independent of NUM_KEYS.
  always_comb begin
    cur_pending = 1'b0;
    cur_state   = 1'b0;
    for (int unsigned i = 0; i <= NUM_KEYS; i++) begin
      if (ptr == 6'(i)) begin
        cur_pending = pending[i];
        cur_state   = key_state[i];
      end
    end
  end

  // Full comes from the registered count, so a pop in the same cycle does
  // not open a slot for a push.
  assign full  = (count == CNT_FULL);
  assign push  = cur_pending && !full;
  assign stall = cur_pending && full;
  assign pop   = ev_valid && ev_ready;

  // The scanner's clear is applied first and the debounce toggle is ORed in
  // after it. A toggle in the same cycle as the clear therefore keeps the
  // flag set.
  always_comb begin
    pending_nxt = '0;
    for (int unsigned i = 0; i <= NUM_KEYS; i++) begin
      pending_nxt[i] = accept[i] | (pending[i] & ~(push && (ptr == 6'(i))));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending     <= '0;
      pending_any <= 1'b0;
      ptr         <= '0;
    end else begin
      pending     <= pending_nxt;
      pending_any <= |pending_nxt;
      if (!stall) begin
        ptr <= (ptr == PTR_LAST) ? '0 : ptr + 6'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO: first-word fall-through, entry = {key[5:0], on}.
  // The storage has no reset. Stale entries are never visible because the
  // outputs are gated by ev_valid.
  // ---------------------------------------------------------------------------
  logic [6:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [6:0]    head;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {ptr, cur_state};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head     = mem[rd_ptr];
  assign ev_valid = (count != '0);
  assign ev_key   = ev_valid ? head[6:1] : '0;
  assign ev_on    = ev_valid ? head[0]   : 1'b0;

endmodule

// File: tb/tb_key_event_queue.sv
// Testbench for key_event_queue: directed scenarios plus randomized traffic.
// Every cycle is compared against a behavioural model built from timestamps
// and a queue.
module tb_key_event_queue;

  localparam int unsigned NK    = 39;
  localparam int unsigned S     = 4;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NK:0]   key_down = '0;
  logic          ev_ready = 1'b0;
  logic [NK:0]   key_state;
  logic          ev_valid;
  logic [5:0]    ev_key;
  logic          ev_on;
  logic          pending_any;

  key_event_queue #(
    .NUM_KEYS     (NK),
    .STABLE_CYCLES(S),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_down   (key_down),
    .key_state  (key_state),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_key     (ev_key),
    .ev_on      (ev_on),
    .pending_any(pending_any)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model.
  // A key is accepted once its sampled level has differed from the accepted
  // level for S edges, measured from the edge where that level was first
  // sampled.
  int unsigned t = 0;
  int unsigned m_since [NK+1];
  logic [NK:0] m_raw   = '0;
  logic [NK:0] m_state = '0;
  logic [NK:0] m_pend  = '0;
  logic        m_pany  = 1'b0;
  int          m_ptr   = 0;
  logic [6:0]  mq [$];

  // Events seen leaving the DUT, plus a count of cycles with ev_valid high.
  logic [6:0]  obs_q [$];
  int          nvalid = 0;

  task automatic model_reset();
    m_raw = '0; m_state = '0; m_pend = '0; m_pany = 1'b0; m_ptr = 0;
    mq.delete();
  endtask

  task automatic model_edge();
    logic [NK:0] acc;
    logic        full, push, pop, stall;
    logic [6:0]  entry;
    t++;
    pop  = (mq.size() != 0) && ev_ready;
    full = (mq.size() == DEPTH);
    for (int i = 0; i <= NK; i++)
      acc[i] = (m_raw[i] != m_state[i]) && (t >= m_since[i] + S);
    push  = m_pend[m_ptr] && !full;
    stall = m_pend[m_ptr] && full;
    entry = {6'(m_ptr), m_state[m_ptr]};
    if (push) m_pend[m_ptr] = 1'b0;
    m_pend = m_pend | acc;
    for (int i = 0; i <= NK; i++)
      if (acc[i]) m_state[i] = m_raw[i];
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(entry);
    if (!stall) m_ptr = (m_ptr == NK) ? 0 : m_ptr + 1;
    for (int i = 0; i <= NK; i++)
      if (key_down[i] != m_raw[i]) m_since[i] = t;
    m_raw  = key_down;
    m_pany = |m_pend;
  endtask

  task automatic compare();
    logic [6:0] h;
    h = (mq.size() != 0) ? mq[0] : 7'd0;
    check("key_state",   key_state,   m_state);
    check("ev_valid",    ev_valid,    mq.size() != 0);
    check("ev_key",      ev_key,      h[6:1]);
    check("ev_on",       ev_on,       h[0]);
    check("pending_any", pending_any, m_pany);
  endtask

  // Called at the negedge with inputs already driven. Records a pop taking
  // place at the coming edge, then advances one cycle.
  task automatic cycle();
    if (rst) begin
      if (ev_valid) nvalid++;
      if (ev_valid && ev_ready) obs_q.push_back({ev_key, ev_on});
    end
    @(posedge clk);
    if (rst) model_edge();
    #1;
    compare();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int cnt_a, cnt_b, lat;
    for (int i = 0; i <= NK; i++) m_since[i] = 0;

    // Reset state.
    run(2);
    rst = 1'b1;

    // Clean press and release of key 5.
    ev_ready = 1'b1;
    obs_q.delete();
    key_down[5] = 1'b1;
    run(20);
    key_down[5] = 1'b0;
    run(20 + NK + 5);
    check("clean_n", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check("clean_ev0", obs_q[0], {6'd5, 1'b1});
      check("clean_ev1", obs_q[1], {6'd5, 1'b0});
    end

    // Glitch rejection on key 7.
    nvalid = 0;
    key_down[7] = 1'b1;
    run(3);
    key_down[7] = 1'b0;
    run(30);
    check("glitch_valid", nvalid, 0);
    check("glitch_state", key_state[7], 1'b0);

    // Simultaneous keys 0, 12 and 39.
    obs_q.delete();
    key_down[0] = 1'b1; key_down[12] = 1'b1; key_down[39] = 1'b1;
    run(S + NK + 10);
    check("simul_n", obs_q.size(), 3);
    cnt_a = 0; cnt_b = 0;
    foreach (obs_q[i]) begin cnt_a += int'(obs_q[i][6:1]); cnt_b += int'(obs_q[i][0]); end
    check("simul_keysum", cnt_a, 51);
    check("simul_on", cnt_b, 3);
    key_down = '0;
    run(S + NK + 10);

    // Backpressure: 10 keys with ev_ready low, then coalesce key 3.
    obs_q.delete();
    ev_ready = 1'b0;
    for (int k = 20; k < 30; k++) key_down[k] = 1'b1;
    run(S + 2 * (NK + 1) + 5);
    check("bp_valid", ev_valid, 1'b1);
    check("bp_pany", pending_any, 1'b1);
    key_down[3] = 1'b1;
    run(S + 3);
    key_down[3] = 1'b0;
    run(S + 3);
    check("coal_pany", pending_any, 1'b1);
    ev_ready = 1'b1;
    run(3 * (NK + 1));
    check("bp_n", obs_q.size(), 11);
    cnt_a = 0; cnt_b = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i] == {6'd3, 1'b0}) cnt_a++;
      if (obs_q[i][0] && obs_q[i][6:1] >= 6'd20 && obs_q[i][6:1] < 6'd30) cnt_b++;
    end
    check("coal_key3_off", cnt_a, 1);
    check("bp_on_events", cnt_b, 10);
    key_down = '0;
    run(S + 2 * (NK + 1));

    // Reset with 5 events queued and key 2 held.
    ev_ready = 1'b0;
    key_down[2] = 1'b1;
    for (int k = 30; k < 34; k++) key_down[k] = 1'b1;
    run(S + NK + 5);
    check("pre_rst_valid", ev_valid, 1'b1);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_ev_valid",  ev_valid,    1'b0);
    check("rst_ev_key",    ev_key,      6'd0);
    check("rst_ev_on",     ev_on,       1'b0);
    check("rst_pany",      pending_any, 1'b0);
    check("rst_key_state", key_state,   '0);
    @(negedge clk);
    key_down = '0;
    key_down[2] = 1'b1;
    run(3);
    rst = 1'b1;
    ev_ready = 1'b1;
    obs_q.delete();
    lat = -1;
    for (int n = 1; n <= int'(NK + S + 10); n++) begin
      cycle();
      if (lat < 0 && ev_valid) lat = n;
    end
    check("rst_latency_ok", (lat >= int'(S + 1)) && (lat <= int'(NK + S + 2)), 1'b1);
    check("rst_n", obs_q.size(), 1);
    if (obs_q.size() == 1) check("rst_ev", obs_q[0], {6'd2, 1'b1});

    // Randomized traffic with varying backpressure.
    for (int blk = 0; blk < 10; blk++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(100);
      for (int c = 0; c < 200; c++) begin
        for (int k = 0; k <= NK; k++)
          if ($urandom_range(47) == 0) key_down[k] = ~key_down[k];
        ev_ready = ($urandom_range(99) < rdy_pct);
        cycle();
      end
    end
    ev_ready = 1'b1;
    run(4 * (NK + 1) + 20);
    check("final_drained", ev_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
